// File: rtl/coherence_pkg.sv
// Shared types and helpers for the per-core MESI snoop responder.
// Optional statistics counters in snoop_responder are enabled by SNOOP_STATS_EN.
package coherence_pkg;

    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        I = 2'd0,
        S = 2'd1,
        E = 2'd2,
        M = 2'd3
    } mesi_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        CB_WAIT = 2'd2,
        RESP    = 2'd3
    } snoop_fsm_t;

    // Line state after a local Memory-stage access
    function automatic mesi_t local_next(mesi_t cur, logic is_wr, logic fill_shared);
        mesi_t nxt;
        nxt = cur;
        if (is_wr) begin
            nxt = M;
        end else if (cur == I) begin
            nxt = fill_shared ? S : E;
        end
        return nxt;
    endfunction

    // Line state after answering a remote snoop
    function automatic mesi_t snoop_next(mesi_t cur, logic is_wr);
        mesi_t nxt;
        nxt = cur;
        if (is_wr) begin
            nxt = I;
        end else if (cur == M || cur == E) begin
            nxt = S;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/line_state_table.sv
// Per-line MESI state array with a local and a snoop read port; snoop writes
// win, and local accesses colliding with the in-flight snoop line are retried.
module line_state_table
    import coherence_pkg::*;
#(
    parameter int unsigned LINES  = 32,
    parameter int unsigned ADDR_W = $clog2(LINES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              loc_valid,
    input  logic              loc_wr,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_fill_shared,
    output mesi_t             loc_state,
    output logic              loc_retry,
    input  logic              snp_busy,
    input  logic [ADDR_W-1:0] snp_addr,
    input  logic              snp_we,
    input  mesi_t             snp_wstate,
    output mesi_t             snp_state
);

    mesi_t state_q [LINES];
    mesi_t state_d [LINES];
    logic  loc_upd;

    assign loc_state = state_q[loc_addr];
    assign snp_state = state_q[snp_addr];

    always_comb begin
        loc_retry = loc_valid && snp_busy && (loc_addr == snp_addr);
        loc_upd   = loc_valid && !loc_retry;
        for (int i = 0; i < LINES; i++) begin
            state_d[i] = state_q[i];
            if (snp_we && (snp_addr == ADDR_W'(i))) begin
                state_d[i] = snp_wstate;
            end else if (loc_upd && (loc_addr == ADDR_W'(i))) begin
                state_d[i] = local_next(state_q[i], loc_wr, loc_fill_shared);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= I;
            end
        end else begin
            for (int i = 0; i < LINES; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

endmodule

// File: rtl/snoop_responder.sv
// Answers the remote core's rd/wr intents against local MESI state, copying back
// Modified lines first. Define SNOOP_STATS_EN to add saturating snoop statistics.
module snoop_responder
    import coherence_pkg::*;
#(
    parameter int unsigned LINES  = 32,
    parameter int unsigned ADDR_W = $clog2(LINES),
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              snp_valid,
    input  logic              snp_rd_intent,
    input  logic              snp_wr_intent,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              snp_ready,
    output logic              snp_done,
    output logic              snp_shared,
    output logic              copy_back,
    output logic [ADDR_W-1:0] cb_addr,
    output logic [DATA_W-1:0] cb_data,
    input  logic [DATA_W-1:0] loc_line_data,
    input  logic              main_mem_ack,
    input  logic              loc_valid,
    input  logic              loc_wr,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic              loc_fill_shared,
    output logic [1:0]        loc_state,
    output logic              loc_retry
`ifdef SNOOP_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_invals,
    output logic [STAT_W-1:0] stat_copybacks
`endif
);

    snoop_fsm_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              hit_q, hit_d;
    logic              snp_we;
    mesi_t             snp_state, snp_wstate, loc_state_e;

    // Write intent wins over read; a request with neither intent is a read.
    logic intent_unused;
    assign intent_unused = snp_rd_intent;

    line_state_table #(
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) u_table (
        .clk             (clk),
        .reset           (reset),
        .loc_valid       (loc_valid),
        .loc_wr          (loc_wr),
        .loc_addr        (loc_addr),
        .loc_fill_shared (loc_fill_shared),
        .loc_state       (loc_state_e),
        .loc_retry       (loc_retry),
        .snp_busy        (state_q != IDLE),
        .snp_addr        (addr_q),
        .snp_we          (snp_we),
        .snp_wstate      (snp_wstate),
        .snp_state       (snp_state)
    );

    assign loc_state = loc_state_e;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        hit_d      = hit_q;
        snp_we     = 1'b0;
        snp_wstate = snoop_next(snp_state, wr_q);
        case (state_q)
            IDLE: begin
                if (snp_valid) begin
                    addr_d  = snp_addr;
                    wr_d    = snp_wr_intent;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                hit_d   = (snp_state != I);
                state_d = (snp_state == M) ? CB_WAIT : RESP;
            end
            CB_WAIT: begin
                if (main_mem_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                snp_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            hit_q   <= hit_d;
        end
    end

    // Outputs decode the registered FSM state, so reset clears them immediately.
    assign snp_ready  = (state_q == IDLE);
    assign copy_back  = (state_q == CB_WAIT);
    assign snp_done   = (state_q == RESP);
    assign snp_shared = snp_done && hit_q && !wr_q;
    assign cb_addr    = copy_back ? addr_q : '0;
    assign cb_data    = copy_back ? loc_line_data : '0;

`ifdef SNOOP_STATS_EN
    logic [STAT_W-1:0] hits_q, hits_d;
    logic [STAT_W-1:0] invals_q, invals_d;
    logic [STAT_W-1:0] cbs_q, cbs_d;

    // Saturating event counters
    always_comb begin
        hits_d   = hits_q;
        invals_d = invals_q;
        cbs_d    = cbs_q;
        if (snp_done && hit_q && (hits_q != '1)) begin
            hits_d = hits_q + STAT_W'(1);
        end
        if (snp_done && hit_q && wr_q && (invals_q != '1)) begin
            invals_d = invals_q + STAT_W'(1);
        end
        if (copy_back && main_mem_ack && (cbs_q != '1)) begin
            cbs_d = cbs_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits_q   <= '0;
            invals_q <= '0;
            cbs_q    <= '0;
        end else begin
            hits_q   <= hits_d;
            invals_q <= invals_d;
            cbs_q    <= cbs_d;
        end
    end

    assign stat_hits      = hits_q;
    assign stat_invals    = invals_q;
    assign stat_copybacks = cbs_q;
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Self-checking bench for snoop_responder: directed scenarios plus randomized
// snoop/local traffic against a line-level MESI reference model.
module tb_snoop_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        snp_valid, snp_rd_intent, snp_wr_intent;
    logic [4:0]  snp_addr;
    logic        snp_ready, snp_done, snp_shared, copy_back;
    logic [4:0]  cb_addr;
    logic [31:0] cb_data, loc_line_data;
    logic        main_mem_ack;
    logic        loc_valid, loc_wr, loc_fill_shared;
    logic [4:0]  loc_addr;
    logic [1:0]  loc_state;
    logic        loc_retry;
`ifdef SNOOP_STATS_EN
    logic [15:0] stat_hits, stat_invals, stat_copybacks;
`endif

    int errors = 0;
    int checks = 0;
    int mdl [32];
    bit blk = 1'b0;
    int blk_addr = 0;

    snoop_responder dut (
        .clk             (clk),
        .reset           (reset),
        .snp_valid       (snp_valid),
        .snp_rd_intent   (snp_rd_intent),
        .snp_wr_intent   (snp_wr_intent),
        .snp_addr        (snp_addr),
        .snp_ready       (snp_ready),
        .snp_done        (snp_done),
        .snp_shared      (snp_shared),
        .copy_back       (copy_back),
        .cb_addr         (cb_addr),
        .cb_data         (cb_data),
        .loc_line_data   (loc_line_data),
        .main_mem_ack    (main_mem_ack),
        .loc_valid       (loc_valid),
        .loc_wr          (loc_wr),
        .loc_addr        (loc_addr),
        .loc_fill_shared (loc_fill_shared),
        .loc_state       (loc_state),
        .loc_retry       (loc_retry)
`ifdef SNOOP_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_invals     (stat_invals),
        .stat_copybacks  (stat_copybacks)
`endif
    );

    always #5 clk = ~clk;

    // Advance one cycle, applying the pending local access to the model unless it collides
    task automatic tick();
        if (loc_valid && !(blk && int'(loc_addr) == blk_addr)) begin
            if (loc_wr) mdl[loc_addr] = 3;
            else if (mdl[loc_addr] == 0) mdl[loc_addr] = loc_fill_shared ? 1 : 2;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic snoop_model(input int a, input bit wr);
        if (wr) mdl[a] = 0;
        else if (mdl[a] >= 2) mdl[a] = 1;
    endtask

    task automatic idle_inputs();
        snp_valid = 0; snp_rd_intent = 0; snp_wr_intent = 0; snp_addr = 0;
        main_mem_ack = 0; loc_line_data = 0;
        loc_valid = 0; loc_wr = 0; loc_addr = 0; loc_fill_shared = 0;
    endtask

    task automatic rand_local(input int a);
        loc_valid       = 1'($urandom_range(0, 1));
        loc_wr          = 1'($urandom_range(0, 1));
        loc_fill_shared = 1'($urandom_range(0, 1));
        loc_addr        = ($urandom_range(0, 2) == 0) ? 5'(a) : 5'($urandom_range(0, 31));
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        #1;
        checks++; if (snp_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", snp_ready); end
        checks++; if (snp_done !== 1'b0 || snp_shared !== 1'b0) begin errors++; $display("FAIL reset_done: got %b%b want 00", snp_done, snp_shared); end
        checks++; if (copy_back !== 1'b0 || cb_addr !== 5'd0 || cb_data !== 32'd0) begin errors++; $display("FAIL reset_cb: got %b %0d %h want 0 0 0", copy_back, cb_addr, cb_data); end
        checks++; if (loc_retry !== 1'b0 || loc_state !== 2'd0) begin errors++; $display("FAIL reset_loc: got %b %0d want 0 0", loc_retry, loc_state); end
    endtask

    task automatic test_read_shared();
        loc_valid = 1; loc_wr = 0; loc_addr = 5; loc_fill_shared = 0;
        tick();
        loc_valid = 0;
        #1;
        checks++; if (loc_state !== 2'd2) begin errors++; $display("FAIL read_fill_e: got %0d want 2", loc_state); end
        snp_valid = 1; snp_rd_intent = 1; snp_addr = 5;
        tick();
        idle_inputs(); loc_addr = 5;
        #1;
        checks++; if (snp_done !== 1'b0 || copy_back !== 1'b0) begin errors++; $display("FAIL rd_lookup: got done=%b cb=%b want 0 0", snp_done, copy_back); end
        tick();
        checks++; if (snp_done !== 1'b1 || snp_shared !== 1'b1 || copy_back !== 1'b0) begin errors++; $display("FAIL rd_resp: got done=%b sh=%b cb=%b want 1 1 0", snp_done, snp_shared, copy_back); end
        tick();
        snoop_model(5, 0);
        checks++; if (loc_state !== 2'd1 || snp_done !== 1'b0) begin errors++; $display("FAIL rd_after: got st=%0d done=%b want 1 0", loc_state, snp_done); end
    endtask

    task automatic test_copyback_collision();
        loc_valid = 1; loc_wr = 1; loc_addr = 9;
        tick();
        idle_inputs();
        loc_line_data = 32'hDEADBEEF;
        snp_valid = 1; snp_wr_intent = 1; snp_addr = 9;
        tick();
        snp_valid = 0; snp_wr_intent = 0;
        blk = 1; blk_addr = 9;
        tick();
        for (int c = 0; c < 3; c++) begin
            loc_valid = (c < 2); loc_wr = 1; loc_addr = (c == 0) ? 5'd9 : 5'd10;
            #1;
            checks++; if (copy_back !== 1'b1 || cb_addr !== 5'd9 || cb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL cb_wait%0d: got %b %0d %h want 1 9 deadbeef", c, copy_back, cb_addr, cb_data); end
            checks++; if (loc_retry !== (c == 0)) begin errors++; $display("FAIL cb_retry%0d: got %b want %b", c, loc_retry, (c == 0)); end
            tick();
        end
        loc_valid = 0; loc_addr = 9;
        #1;
        checks++; if (loc_state !== 2'd3 || snp_done !== 1'b0) begin errors++; $display("FAIL cb_hold: got st=%0d done=%b want 3 0", loc_state, snp_done); end
        main_mem_ack = 1;
        tick();
        main_mem_ack = 0;
        checks++; if (snp_done !== 1'b1 || snp_shared !== 1'b0 || copy_back !== 1'b0) begin errors++; $display("FAIL cb_resp: got done=%b sh=%b cb=%b want 1 0 0", snp_done, snp_shared, copy_back); end
        tick();
        snoop_model(9, 1);
        blk = 0;
        checks++; if (loc_state !== 2'd0) begin errors++; $display("FAIL cb_inval: got %0d want 0", loc_state); end
        loc_addr = 10;
        #1;
        checks++; if (loc_state !== 2'd3) begin errors++; $display("FAIL other_line_m: got %0d want 3", loc_state); end
    endtask

    task automatic test_read_invalid();
        idle_inputs();
        snp_valid = 1; snp_rd_intent = 1; snp_addr = 0;
        tick();
        idle_inputs();
        tick();
        checks++; if (snp_done !== 1'b1 || snp_shared !== 1'b0) begin errors++; $display("FAIL rd_inv_resp: got done=%b sh=%b want 1 0", snp_done, snp_shared); end
        tick();
        checks++; if (loc_state !== 2'd0) begin errors++; $display("FAIL rd_inv_state: got %0d want 0", loc_state); end
    endtask

    task automatic test_random(input int n);
        for (int it = 0; it < n; it++) begin
            int a, pre, w;
            bit wr;
            logic [31:0] d;
            a = $urandom_range(0, 31);
            for (int k = 0; k < 3; k++) begin
                rand_local(a);
                #1;
                checks++; if (loc_state !== 2'(mdl[loc_addr])) begin errors++; $display("FAIL rnd_warm_state: addr=%0d got %0d want %0d", loc_addr, loc_state, mdl[loc_addr]); end
                tick();
            end
            checks++; if (snp_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready: got %b want 1", snp_ready); end
            snp_valid = 1; snp_rd_intent = 1'($urandom_range(0, 1)); snp_wr_intent = 1'($urandom_range(0, 1)); snp_addr = 5'(a);
            wr = snp_wr_intent;
            rand_local(a);
            tick();
            snp_valid = 0; snp_rd_intent = 0; snp_wr_intent = 0;
            pre = mdl[a]; blk = 1; blk_addr = a;
            rand_local(a);
            #1;
            checks++; if (snp_ready !== 1'b0 || snp_done !== 1'b0 || loc_retry !== (loc_valid && int'(loc_addr) == a)) begin errors++; $display("FAIL rnd_lookup: rdy=%b done=%b retry=%b want 0 0 %b", snp_ready, snp_done, loc_retry, (loc_valid && int'(loc_addr) == a)); end
            tick();
            if (pre == 3) begin
                w = $urandom_range(0, 3);
                for (int c = 0; c <= w; c++) begin
                    d = $urandom; loc_line_data = d; main_mem_ack = (c == w);
                    rand_local(a);
                    #1;
                    checks++; if (copy_back !== 1'b1 || int'(cb_addr) != a || cb_data !== d || snp_done !== 1'b0) begin errors++; $display("FAIL rnd_cb: cb=%b addr=%0d data=%h done=%b want 1 %0d %h 0", copy_back, cb_addr, cb_data, snp_done, a, d); end
                    checks++; if (loc_retry !== (loc_valid && int'(loc_addr) == a)) begin errors++; $display("FAIL rnd_cb_retry: got %b", loc_retry); end
                    tick();
                end
                main_mem_ack = 0;
            end
            rand_local(a);
            #1;
            checks++; if (snp_done !== 1'b1 || snp_shared !== (!wr && pre != 0) || copy_back !== 1'b0) begin errors++; $display("FAIL rnd_resp: done=%b sh=%b cb=%b want 1 %b 0 (pre=%0d wr=%b)", snp_done, snp_shared, copy_back, (!wr && pre != 0), pre, wr); end
            checks++; if (loc_retry !== (loc_valid && int'(loc_addr) == a)) begin errors++; $display("FAIL rnd_resp_retry: got %b", loc_retry); end
            tick();
            snoop_model(a, wr);
            blk = 0;
            loc_valid = 0; loc_addr = 5'(a);
            #1;
            checks++; if (loc_state !== 2'(mdl[a]) || snp_ready !== 1'b1 || snp_done !== 1'b0) begin errors++; $display("FAIL rnd_after: st=%0d rdy=%b done=%b want %0d 1 0", loc_state, snp_ready, snp_done, mdl[a]); end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        loc_valid = 1; loc_wr = 1; loc_addr = 7;
        tick();
        idle_inputs();
        snp_valid = 1; snp_wr_intent = 1; snp_addr = 7;
        tick();
        idle_inputs();
        tick();
        checks++; if (copy_back !== 1'b1) begin errors++; $display("FAIL mid_cb_on: got %b want 1", copy_back); end
        reset = 1;
        #1;
        checks++; if (copy_back !== 1'b0 || snp_ready !== 1'b1 || snp_done !== 1'b0) begin errors++; $display("FAIL mid_reset: cb=%b rdy=%b done=%b want 0 1 0", copy_back, snp_ready, snp_done); end
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 32; i++) mdl[i] = 0;
        for (int i = 0; i < 32; i++) begin
            loc_addr = 5'(i);
            #1;
            checks++; if (loc_state !== 2'(mdl[i])) begin errors++; $display("FAIL mid_lines: addr=%0d got %0d want 0", i, loc_state); end
        end
        tick();
        checks++; if (snp_done !== 1'b0 || snp_ready !== 1'b1) begin errors++; $display("FAIL mid_no_resp: done=%b rdy=%b want 0 1", snp_done, snp_ready); end
    endtask

`ifdef SNOOP_STATS_EN
    task automatic test_stats();
        int budget;
        bit seen;
        idle_inputs();
        checks++; if (stat_hits !== 16'd0 || stat_invals !== 16'd0 || stat_copybacks !== 16'd0) begin errors++; $display("FAIL stats_clear: got %0d %0d %0d want 0 0 0", stat_hits, stat_invals, stat_copybacks); end
        for (int k = 1; k <= 4; k++) begin
            loc_valid = 1; loc_wr = (k == 4); loc_addr = 5'(k); loc_fill_shared = 0;
            tick();
        end
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            snp_valid = 1; snp_rd_intent = (k != 4); snp_wr_intent = (k == 4); snp_addr = 5'(k);
            tick();
            idle_inputs();
            seen = 0;
            budget = 0;
            while (!seen && budget < 10) begin
                main_mem_ack = copy_back;
                seen = snp_done;
                tick();
                budget++;
            end
            checks++; if (!seen) begin errors++; $display("FAIL stats_timeout: snoop %0d got no snp_done within 10 cycles", k); end
        end
        checks++; if (stat_hits !== 16'd4 || stat_invals !== 16'd1 || stat_copybacks !== 16'd1) begin errors++; $display("FAIL stats_counts: got %0d %0d %0d want 4 1 1", stat_hits, stat_invals, stat_copybacks); end
    endtask
`endif

    initial begin
        test_reset();
        test_read_shared();
        test_copyback_collision();
        test_read_invalid();
        test_random(60);
        test_reset_mid();
`ifdef SNOOP_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
